// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer
//   Ping-pong payload buffer between the ADC sample averager and the 10BASE-T
//   transmitter. Averaged samples fill the write bank while the transmitter
//   reads the other bank; full banks are handed over with a ready/done
//   handshake. Samples that arrive while both banks are occupied are dropped
//   and counted.
//
// Ports
//   clk20        20 MHz system clock, rising edge
//   rst_n        asynchronous active-low reset
//   avg_data     averaged ADC sample
//   avg_valid    one-cycle strobe, avg_data valid
//   rd_addr      transmitter byte address within the presented frame
//   rd_data      registered read data (1-cycle latency, 0x00 beyond payload)
//   frame_ready  a complete frame is presented on the read bank
//   frame_done   one-cycle strobe, transmitter finished the presented frame
//   frame_seq    sequence number of the presented frame (wraps 255->0)
//   overflow     sticky, at least one sample dropped
//   drop_count   saturating count of dropped samples
//   clr_overflow one-cycle strobe, clears overflow and drop_count
module adc_frame_buffer #(
    parameter int PAYLOAD_LEN = 18,
    parameter int ADDR_W      = 5,
    parameter int CNT_W       = 16
) (
    input  logic              clk20,
    input  logic              rst_n,
    input  logic [7:0]        avg_data,
    input  logic              avg_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frame_ready,
    input  logic              frame_done,
    output logic [7:0]        frame_seq,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count,
    input  logic              clr_overflow
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(PAYLOAD_LEN - 1);
    // One extra bit so a payload of exactly 2^ADDR_W bytes still compares correctly.
    localparam logic [ADDR_W:0]   LEN      = (ADDR_W + 1)'(PAYLOAD_LEN);

    typedef enum logic {
        W_FILL,
        W_FULL
    } w_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_READY,
        RD_GAP
    } rd_state_t;

    w_state_t          w_state, w_next;
    rd_state_t         rd_state, rd_next;

    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_ptr;

    logic              rd_free;
    logic              swap;
    logic              drop;
    logic              wr_en;
    logic              last_wr;

    logic [7:0]        mem [2][PAYLOAD_LEN];

    // Both FSMs are decided together: the handover (swap) depends on the
    // write side having a full bank and the read side having released its bank.
    always_comb begin
        w_next      = w_state;
        rd_next     = rd_state;
        swap        = 1'b0;
        drop        = 1'b0;
        wr_en       = 1'b0;
        last_wr     = 1'b0;
        rd_free     = (rd_state == RD_IDLE) || (rd_state == RD_GAP);
        frame_ready = (rd_state == RD_READY);

        case (w_state)
            W_FILL: begin
                if (avg_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_PTR) begin
                        last_wr = 1'b1;
                        if (rd_free) begin
                            swap = 1'b1;
                        end else begin
                            w_next = W_FULL;
                        end
                    end
                end
            end
            W_FULL: begin
                drop = avg_valid;
                if (rd_free) begin
                    swap   = 1'b1;
                    w_next = W_FILL;
                end
            end
        endcase

        case (rd_state)
            RD_IDLE:  if (swap) rd_next = RD_READY;
            RD_READY: if (frame_done) rd_next = RD_GAP;
            RD_GAP:   rd_next = swap ? RD_READY : RD_IDLE;
            default:  rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk20 or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_FILL;
            rd_state  <= RD_IDLE;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b1;
            wr_ptr    <= '0;
            frame_seq <= '0;
        end else begin
            w_state  <= w_next;
            rd_state <= rd_next;
            if (swap) begin
                rd_bank   <= wr_bank;
                wr_bank   <= ~wr_bank;
                wr_ptr    <= '0;
                frame_seq <= frame_seq + 8'd1;
            end else if (wr_en) begin
                // Pointer is unused while full; parking it at 0 avoids
                // overflowing ADDR_W when the payload fills the address space.
                wr_ptr <= last_wr ? '0 : wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk20 or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow) begin
                drop_count <= CNT_W'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    // Sample storage is intentionally not reset.
    always_ff @(posedge clk20) begin
        if (wr_en) begin
            mem[wr_bank][wr_ptr] <= avg_data;
        end
    end

    always_ff @(posedge clk20 or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < LEN) begin
            rd_data <= mem[rd_bank][rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_adc_frame_buffer.sv
// tb_adc_frame_buffer
//   Self-checking bench for adc_frame_buffer. A frame-level reference model
//   (partial fill queue, pending-full flag, presented frame copy) predicts
//   every output after each clock edge; directed scenarios are followed by a
//   randomized phase.
module tb_adc_frame_buffer;

    localparam int LEN  = 18;
    localparam int AW   = 5;
    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk20;
    logic          rst_n;
    logic [7:0]    avg_data;
    logic          avg_valid;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_ready;
    logic          frame_done;
    logic [7:0]    frame_seq;
    logic          overflow;
    logic [CW-1:0] drop_count;
    logic          clr_overflow;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [7:0] m_fill[$];
    logic [7:0] m_shown[$];
    bit         m_full;
    bit         m_ready;
    int         m_seq;
    bit         m_ovf;
    int         m_drops;
    logic [7:0] m_rd;
    bit         m_rd_known;

    adc_frame_buffer #(
        .PAYLOAD_LEN(LEN),
        .ADDR_W     (AW),
        .CNT_W      (CW)
    ) dut (
        .clk20       (clk20),
        .rst_n       (rst_n),
        .avg_data    (avg_data),
        .avg_valid   (avg_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_done  (frame_done),
        .frame_seq   (frame_seq),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .clr_overflow(clr_overflow)
    );

    initial clk20 = 1'b0;
    always #25 clk20 = ~clk20;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fill.delete();
        m_shown.delete();
        m_full     = 1'b0;
        m_ready    = 1'b0;
        m_seq      = 0;
        m_ovf      = 1'b0;
        m_drops    = 0;
        m_rd       = 8'h00;
        m_rd_known = 1'b1;
    endtask

    // One clock edge of the reference: the reader can accept a frame whenever it
    // is not holding one; a full pending bank or a last byte is handed over then.
    task automatic model_step(input logic v, input logic [7:0] d, input logic done,
                              input logic clr, input int addr);
        bit drop;
        if (addr >= LEN) begin
            m_rd = 8'h00;
            m_rd_known = 1'b1;
        end else if (m_shown.size() == LEN) begin
            m_rd = m_shown[addr];
            m_rd_known = 1'b1;
        end else begin
            m_rd_known = 1'b0;
        end

        drop = v && m_full;

        if (!m_ready) begin
            if (m_full || (v && m_fill.size() == LEN - 1)) begin
                if (!m_full) m_fill.push_back(d);
                m_shown = m_fill;
                m_fill.delete();
                m_full  = 1'b0;
                m_ready = 1'b1;
                m_seq   = (m_seq + 1) % 256;
            end else if (v) begin
                m_fill.push_back(d);
            end
        end else begin
            if (v && !m_full) begin
                m_fill.push_back(d);
                if (m_fill.size() == LEN) m_full = 1'b1;
            end
            if (done) m_ready = 1'b0;
        end

        if (drop) begin
            m_ovf = 1'b1;
            if (clr) m_drops = 1;
            else if (m_drops < CMAX) m_drops++;
        end else if (clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
    endtask

    task automatic compare_all();
        check("frame_ready", 32'(frame_ready), 32'(m_ready));
        check("frame_seq", 32'(frame_seq), 32'(m_seq));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_count", 32'(drop_count), 32'(m_drops));
        if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic done,
                         input logic clr, input int addr);
        avg_valid    = v;
        avg_data     = d;
        frame_done   = done;
        clr_overflow = clr;
        rd_addr      = addr[AW-1:0];
        @(posedge clk20);
        model_step(v, d, done, clr, addr);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk20);
        rst_n = 1'b0;
        avg_valid = 1'b0; avg_data = 8'h00; frame_done = 1'b0;
        clr_overflow = 1'b0; rd_addr = '0;
        @(negedge clk20);
        @(negedge clk20);
        rst_n = 1'b1;
        model_reset();
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0;
        avg_valid = 1'b0; avg_data = 8'h00; frame_done = 1'b0;
        clr_overflow = 1'b0; rd_addr = '0;
        model_reset();

        // reset state
        do_reset();
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_ready", 32'(frame_ready), 32'h0);

        // first frame, samples spread out
        for (int i = 0; i < LEN; i++) begin
            if (i > 0) idle(127);
            if (i == LEN - 1) check("t1_not_ready", 32'(frame_ready), 32'h0);
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 0);
        end
        check("t1_ready", 32'(frame_ready), 32'h1);
        check("t1_seq", 32'(frame_seq), 32'h1);
        for (int a = 0; a < LEN; a++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
            check("t1_rd", 32'(rd_data), 32'(a));
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 20);
        check("t1_rd_oob", 32'(rd_data), 32'h0);

        // release with nothing pending
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
        check("t2_ready_low", 32'(frame_ready), 32'h0);
        idle(5);
        check("t2_stay_low", 32'(frame_ready), 32'h0);
        check("t2_seq", 32'(frame_seq), 32'h1);

        // both banks fill while the reader holds its frame
        do_reset();
        for (int i = 0; i < 39; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 0);
        check("t3_ready", 32'(frame_ready), 32'h1);
        check("t3_seq1", 32'(frame_seq), 32'h1);
        check("t3_ovf", 32'(overflow), 32'h1);
        check("t3_drops", 32'(drop_count), 32'h3);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
        check("t3_gap", 32'(frame_ready), 32'h0);
        idle(1);
        check("t3_ready2", 32'(frame_ready), 32'h1);
        check("t3_seq2", 32'(frame_seq), 32'h2);
        for (int a = 0; a < LEN; a++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
            check("t3_rd", 32'(rd_data), 32'(8'h52 + a));
        end

        // last byte coincides with frame_done
        for (int i = 0; i < LEN - 1; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 0);
        cycle(1'b1, 8'hA5, 1'b1, 1'b0, 0);
        check("t4_gap", 32'(frame_ready), 32'h0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, LEN - 1);
        check("t4_ready", 32'(frame_ready), 32'h1);
        check("t4_seq", 32'(frame_seq), 32'h3);
        check("t4_no_drop", 32'(drop_count), 32'h3);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, LEN - 1);
        check("t4_rd_last", 32'(rd_data), 32'hA5);

        // drop counter saturation and clear priority
        for (int i = 0; i < LEN; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, $urandom_range(0, 31));
        for (int i = 0; i < CMAX + 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, $urandom_range(0, 31));
        check("t5_sat", 32'(drop_count), 32'(CMAX));
        cycle(1'b1, 8'h11, 1'b0, 1'b1, 0);
        check("t5_clr_drop_ovf", 32'(overflow), 32'h1);
        check("t5_clr_drop_cnt", 32'(drop_count), 32'h1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 0);
        check("t5_clr_ovf", 32'(overflow), 32'h0);
        check("t5_clr_cnt", 32'(drop_count), 32'h0);

        // randomized traffic at several sample densities
        for (int c = 0; c < 6; c++) begin
            int pv;
            pv = (c % 3 == 0) ? 15 : ((c % 3 == 1) ? 60 : 100);
            for (int k = 0; k < 500; k++) begin
                cycle(1'($urandom_range(0, 99) < pv), 8'($urandom),
                      1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 199) == 0),
                      $urandom_range(0, 31));
            end
        end

        // asynchronous reset mid-fill
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
        idle(2);
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 3);
        #10;
        rst_n = 1'b0;
        #1;
        check("t6_async_ready", 32'(frame_ready), 32'h0);
        check("t6_async_seq", 32'(frame_seq), 32'h0);
        check("t6_async_ovf", 32'(overflow), 32'h0);
        check("t6_async_cnt", 32'(drop_count), 32'h0);
        check("t6_async_rd", 32'(rd_data), 32'h0);
        @(negedge clk20);
        @(negedge clk20);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < LEN - 1; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 0);
        check("t6_not_ready", 32'(frame_ready), 32'h0);
        cycle(1'b1, 8'h31, 1'b0, 1'b0, 0);
        check("t6_ready", 32'(frame_ready), 32'h1);
        check("t6_seq", 32'(frame_seq), 32'h1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 0);
        check("t6_rd0", 32'(rd_data), 32'h20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
